fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the byte-address width of the program counter.
REQ-002 SHALL have parameter I_WIDTH, default 32, the instruction width in bits.
REQ-003 SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-004 SHALL have parameter BUF_DEPTH, default 2, the output buffer depth in entries (minimum 2).
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 fetch_en  in  1  level; permits new memory requests while high.
REQ-008 redirect_valid  in  1  one-cycle pulse; branch/jump target is present.
REQ-009 redirect_pc  in  PC_WIDTH  redirect target byte address.
REQ-010 imem_req  out  1  request strobe to instruction memory.
REQ-011 imem_addr  out  PC_WIDTH  word-aligned byte address of the request.
REQ-012 imem_rdata  in  I_WIDTH  memory read data, valid exactly 1 cycle after imem_req.
REQ-013 out_valid  out  1  buffered instruction available.
REQ-014 out_ready  in  1  decode accepts; transfer occurs when out_valid and out_ready are both high.
REQ-015 out_instr  out  I_WIDTH  instruction at the buffer head.
REQ-016 out_pc  out  PC_WIDTH  byte address of out_instr.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; reset enters IDLE; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0.
REQ-018 SHALL assert imem_req only in RUN, when redirect_valid=0, and when (count + inflight - pop) < BUF_DEPTH, where pop = out_valid & out_ready.
REQ-019 imem_addr SHALL equal the registered fetch_pc, with bits [1:0] always 0.
REQ-020 On each issued request, fetch_pc SHALL advance by 4, wrapping modulo 2^PC_WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-021 SHALL set the inflight flag on request and write {pc, imem_rdata} into the buffer on the following cycle, unless that response is marked discarded.
REQ-022 out_valid SHALL equal (count != 0), driven from registered state only; out_instr and out_pc SHALL come from the buffer head.
REQ-023 Latency: a request issued in cycle T SHALL appear at out_valid in cycle T+2 if the buffer was empty.
REQ-024 Throughput: with out_ready held high, SHALL sustain one instruction per cycle in steady state.
REQ-025 Redirect in any state SHALL empty the buffer, mark any in-flight response discarded, and load fetch_pc with {redirect_pc[PC_WIDTH-1:2], 2'b00}.
REQ-026 Redirect SHALL suppress imem_req in its own cycle; the first request to the target is issued at T+1 (if in RUN), and out_valid rises at T+3.
REQ-027 A transfer coinciding with redirect SHALL count as flushed; the buffer is emptied regardless of pop.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, and the buffer SHALL never overflow or underflow.
REQ-029 When fetch_en falls, an outstanding response SHALL still be captured; buffered entries SHALL remain available until popped or flushed.
REQ-030 While out_ready=0 the head entry SHALL hold stable.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously and mid-operation: set fetch_pc=RESET_PC, state=IDLE, count=0, inflight=0, discard=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-032 Any response arriving after reset release for a pre-reset request SHALL be ignored.

Structure
REQ-033 Package riscv_pkg SHALL hold PC_WIDTH, I_WIDTH, RESET_PC, and the fetch_state_t enum {IDLE, RUN}.
REQ-034 SHALL instantiate one sub-module, fetch_buf: a synchronous FIFO of BUF_DEPTH entries of {pc, instr} with push, pop, flush and count.
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Reset, then fetch_en=1 with out_ready=1: imem_addr = 0x0, 0x4, 0x8...; out_pc follows two cycles later with matching instructions.
REQ-037 out_ready=0 for 5 cycles: imem_req stops after 2 entries are buffered plus none in flight; out_pc holds; on release, no address is skipped or duplicated.
REQ-038 redirect_valid with redirect_pc=0x103 while 1 entry is in flight: the stale response is dropped, the next imem_addr is 0x100, and out_pc=0x100 at T+3.
REQ-039 fetch_pc=0xFFFFFFFC with out_ready=1: the next request address is 0x00000000.
REQ-040 rst_n asserted mid-stream with the buffer full: all outputs are 0 immediately; after release, fetching restarts at RESET_PC.
REQ-041 fetch_en dropped with 1 request in flight: the response is captured, out_valid stays high until popped, and no further imem_req is issued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path constants and the fetch FSM state type.
// Module parameters take their defaults from here so every instance agrees.
package riscv_pkg;

    localparam int          PC_WIDTH = 32;
    localparam int          I_WIDTH  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of DEPTH {pc, instr} entries with flush; head is zero when empty.
// Latency: push visible at head the cycle after; flush wins over push and pop.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Guards make the FIFO safe even if a caller misbehaves at full/empty.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC requests to a 1-cycle memory, buffered for decode.
// Latency: request to out_valid 2 cycles; requests stop when buffer plus in-flight would overflow.
module fetch_unit #(
    parameter int                  PC_WIDTH  = riscv_pkg::PC_WIDTH,
    parameter int                  I_WIDTH   = riscv_pkg::I_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(riscv_pkg::RESET_PC),
    parameter int                  BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [I_WIDTH-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [I_WIDTH-1:0]  out_instr,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam int              CW      = $clog2(BUF_DEPTH + 1);
    localparam int              EW      = PC_WIDTH + I_WIDTH;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(BUF_DEPTH);

    riscv_pkg::fetch_state_t state;
    riscv_pkg::fetch_state_t state_nxt;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] rsp_pc;
    logic                inflight;
    logic                rsp_discard;
    logic                push;
    logic                pop;
    logic [CW-1:0]       count;
    logic [CW:0]         occupancy;
    logic [EW-1:0]       head;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= riscv_pkg::IDLE;
        else        state <= state_nxt;
    end

    assign pop       = out_valid & out_ready;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        unique case (state)
            riscv_pkg::IDLE: begin
                if (fetch_en) state_nxt = riscv_pkg::RUN;
            end
            riscv_pkg::RUN: begin
                if (!fetch_en) state_nxt = riscv_pkg::IDLE;
                imem_req = !redirect_valid && (occupancy < DEPTH_C);
            end
            default: state_nxt = riscv_pkg::IDLE;
        endcase
    end

    // Memory answers one cycle after the request, so the redirect that kills
    // an in-flight response is always seen in the same cycle as its data.
    assign rsp_discard = inflight & redirect_valid;
    assign push        = inflight & ~rsp_discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
            rsp_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) rsp_pc <= fetch_pc;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            else if (imem_req)
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
        end
    end

    assign imem_addr = fetch_pc;

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (EW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rsp_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head_data (head)
    );

    assign out_valid         = (count != '0);
    assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a queue-based model of issued fetches.
module tb_fetch_unit;

    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_WIDTH  (32),
        .I_WIDTH   (32),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: data valid exactly one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every accepted fetch is expected to reach decode, in order, two cycles
    // after issue, unless a redirect or reset throws it away first.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_addr  = RESET_PC;
    logic        model_run = 1'b0;
    int          cyc_n     = 0;
    logic [31:0] last_req  = '0;
    logic        have_last = 1'b0;
    int          wrap_seen = 0;

    always @(negedge clk) begin
        logic exp_vld;
        logic exp_pop;
        logic exp_req;
        if (!rst_n) begin
            q.delete();
            exp_addr  = RESET_PC;
            model_run = 1'b0;
            have_last = 1'b0;
        end else begin
            cyc_n++;
            exp_pop = 1'b0;
            exp_vld = (q.size() != 0) && (q[0].cyc + 2 <= cyc_n);
            chk("out_valid", out_valid, exp_vld);
            if (exp_vld && out_valid) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr", out_instr, q[0].instr);
                exp_pop = out_ready;
            end
            exp_req = model_run && !redirect_valid
                      && ((q.size() - (exp_pop ? 1 : 0)) < BUF_DEPTH);
            chk("imem_req", imem_req, exp_req);
            if (imem_req) begin
                chk("imem_addr", imem_addr, exp_addr);
                if (have_last && last_req == 32'hFFFF_FFFC && imem_addr == 32'h0)
                    wrap_seen++;
                last_req  = imem_addr;
                have_last = 1'b1;
            end
            if (exp_pop && !redirect_valid) void'(q.pop_front());
            if (redirect_valid) begin
                q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end else if (imem_req) begin
                q.push_back('{pc: exp_addr, instr: mem_word(exp_addr), cyc: cyc_n});
                exp_addr = exp_addr + 32'd4;
            end
            model_run = fetch_en;
        end
    end

    task automatic cyc(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_pc"}, out_pc, 32'h0);
        chk({tag, "_out_instr"}, out_instr, 32'h0);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
    endtask

    initial begin
        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming, backpressure stall, then release.
        repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5)  cyc(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8)  cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with a response in flight, unaligned target.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the space.
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // fetch_en drop with a request in flight; entries held, then drained.
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect while idle, then resume.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, $urandom());
        end

        // Fill the buffer, then reset mid-cycle.
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3)  cyc(1'b0, 1'b1, 1'b0, 32'h0);

        chk("wrap_seen", wrap_seen != 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
